// File: rtl/phase_seq_pkg.sv
// Shared types and helpers for the phase sequencer: state encoding, default
// wait-timer sizing and phase-index to one-hot conversion.
package phase_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } seq_state_e;

    localparam int unsigned DEF_WAIT_W     = 4;
    localparam int unsigned DEF_WAIT_LIMIT = 15;
    localparam int unsigned MAX_PHASES     = 32;

    // Callers truncate the result to their own phase count.
    function automatic logic [MAX_PHASES-1:0] idx_to_onehot(input int unsigned idx);
        return MAX_PHASES'(1) << idx;
    endfunction

endpackage

// File: rtl/phase_sequencer_if.sv
// Control-unit <-> sequencer signal bundle. retire_cnt exists only when
// PHASE_SEQ_RETIRE_CNT_EN is defined.
interface phase_sequencer_if #(
    parameter int unsigned NUM_PHASES = 3,
    parameter int unsigned WAIT_W     = phase_seq_pkg::DEF_WAIT_W
);
    logic [NUM_PHASES-1:0] phase_ready;
    logic                  halt_req;
    logic                  go;
    logic                  step_mode;
    logic [NUM_PHASES-1:0] phase;
    logic                  phase_first;
    logic                  halted;
    logic                  timeout_err;
    logic [WAIT_W-1:0]     wait_cnt;
`ifdef PHASE_SEQ_RETIRE_CNT_EN
    logic [31:0]           retire_cnt;
`endif

    // Control unit side
    modport master (
        output phase_ready, halt_req, go, step_mode,
`ifdef PHASE_SEQ_RETIRE_CNT_EN
        input  retire_cnt,
`endif
        input  phase, phase_first, halted, timeout_err, wait_cnt
    );

    // Sequencer side
    modport slave (
        input  phase_ready, halt_req, go, step_mode,
`ifdef PHASE_SEQ_RETIRE_CNT_EN
        output retire_cnt,
`endif
        output phase, phase_first, halted, timeout_err, wait_cnt
    );

endinterface

// File: rtl/phase_wait_timer.sv
// Wait-state counter for the active phase: clears on phase change, saturates
// at all-ones and flags the last allowed wait cycle (WAIT_LIMIT=0 disables).
module phase_wait_timer #(
    parameter int unsigned WAIT_W     = phase_seq_pkg::DEF_WAIT_W,
    parameter int unsigned WAIT_LIMIT = phase_seq_pkg::DEF_WAIT_LIMIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              clear,
    input  logic              inc,
    output logic [WAIT_W-1:0] wait_cnt,
    output logic              limit_hit_c
);

    localparam logic [WAIT_W-1:0] LIMIT_M1 =
        (WAIT_LIMIT == 0) ? '0 : WAIT_W'(WAIT_LIMIT - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (en) begin
            if (clear) begin
                wait_cnt <= '0;
            end else if (inc && (wait_cnt != '1)) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
        end
    end

    assign limit_hit_c = (WAIT_LIMIT != 0) && (wait_cnt == LIMIT_M1);

endmodule

// File: rtl/phase_sequencer.sv
// NUM_PHASES one-hot instruction-cycle sequencer with wait states, halt/step
// and wait timeout. Optional retire counter: PHASE_SEQ_RETIRE_CNT_EN.
module phase_sequencer
    import phase_seq_pkg::*;
#(
    parameter int unsigned NUM_PHASES = 3,
    parameter int unsigned WAIT_W     = DEF_WAIT_W,
    parameter int unsigned WAIT_LIMIT = DEF_WAIT_LIMIT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    phase_sequencer_if.slave bus
);

    localparam int unsigned      IDX_W    = $clog2(NUM_PHASES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PHASES - 1);

    seq_state_e            state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_PHASES-1:0] phase_q, phase_d;
    logic                  first_q, first_d;
    logic                  halted_q, halted_d;
    logic                  terr_q, terr_d;
    logic                  clr_c, inc_c, limit_hit_c, ready_c;
    logic [WAIT_W-1:0]     wait_cnt;

    assign ready_c = bus.phase_ready[idx_q];

    phase_wait_timer #(
        .WAIT_W     (WAIT_W),
        .WAIT_LIMIT (WAIT_LIMIT)
    ) u_wait_timer (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .clear       (clr_c),
        .inc         (inc_c),
        .wait_cnt    (wait_cnt),
        .limit_hit_c (limit_hit_c)
    );

    // Next-state and next-output decode
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        first_d  = first_q;
        halted_d = halted_q;
        terr_d   = terr_q;
        clr_c    = 1'b0;
        inc_c    = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = RUN;
                idx_d   = '0;
                first_d = 1'b1;
                clr_c   = 1'b1;
            end
            RUN: begin
                if (ready_c) begin
                    clr_c   = 1'b1;
                    first_d = 1'b1;
                    if (idx_q != LAST_IDX) begin
                        idx_d = idx_q + IDX_W'(1);
                    end else begin
                        idx_d = '0;
                        if (bus.halt_req || bus.step_mode) begin
                            state_d  = HALTED;
                            halted_d = 1'b1;
                            first_d  = 1'b0;
                        end
                    end
                end else if (limit_hit_c) begin
                    // Stuck phase: abort the instruction and lock out go
                    state_d  = HALTED;
                    halted_d = 1'b1;
                    terr_d   = 1'b1;
                    first_d  = 1'b0;
                    idx_d    = '0;
                    clr_c    = 1'b1;
                end else begin
                    first_d = 1'b0;
                    inc_c   = 1'b1;
                end
            end
            HALTED: begin
                first_d = 1'b0;
                if (bus.go && !terr_q) begin
                    state_d  = RUN;
                    idx_d    = '0;
                    first_d  = 1'b1;
                    halted_d = 1'b0;
                    clr_c    = 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                idx_d    = '0;
                first_d  = 1'b0;
                halted_d = 1'b0;
            end
        endcase
        phase_d = (state_d == RUN) ? NUM_PHASES'(idx_to_onehot(32'(idx_d))) : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            phase_q  <= '0;
            first_q  <= 1'b0;
            halted_q <= 1'b0;
            terr_q   <= 1'b0;
        end else if (en) begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            phase_q  <= phase_d;
            first_q  <= first_d;
            halted_q <= halted_d;
            terr_q   <= terr_d;
        end
    end

    assign bus.phase       = phase_q;
    assign bus.phase_first = first_q;
    assign bus.halted      = halted_q;
    assign bus.timeout_err = terr_q;
    assign bus.wait_cnt    = wait_cnt;

`ifdef PHASE_SEQ_RETIRE_CNT_EN
    logic        boundary_c;
    logic [31:0] retire_q;

    // Only a completed last phase retires; timeout exits never do
    assign boundary_c = (state_q == RUN) && ready_c && (idx_q == LAST_IDX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retire_q <= '0;
        end else if (en && boundary_c) begin
            retire_q <= retire_q + 32'd1;
        end
    end

    assign bus.retire_cnt = retire_q;
`endif

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer (3 phases, WAIT_LIMIT=4); expected output
// words are queued when a step is driven and popped after the clock edge.
module tb_phase_sequencer;

    logic clk;
    logic reset;
    logic en;

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    logic [9:0] exp_q[$];
    string      tag_q[$];

    phase_sequencer_if #(.NUM_PHASES(3), .WAIT_W(4)) bus ();

    phase_sequencer #(
        .NUM_PHASES (3),
        .WAIT_W     (4),
        .WAIT_LIMIT (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {phase, phase_first, halted, timeout_err, wait_cnt}
    function automatic logic [9:0] ex(input logic [2:0] p, input logic f,
                                      input logic h, input logic t, input logic [3:0] w);
        return {p, f, h, t, w};
    endfunction

    function automatic logic [9:0] cur();
        return {bus.phase, bus.phase_first, bus.halted, bus.timeout_err, bus.wait_cnt};
    endfunction

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_sb();
        logic [9:0] e;
        string      t;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL scoreboard_underflow: observed 0 entries expected 1");
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            cmp(t, 32'(cur()), 32'(e));
        end
    endtask

    task automatic drive(input logic e, input logic [2:0] rdy, input logic hq,
                         input logic g, input logic sm);
        en              = e;
        bus.phase_ready = rdy;
        bus.halt_req    = hq;
        bus.go          = g;
        bus.step_mode   = sm;
    endtask

    task automatic step(input logic e, input logic [2:0] rdy, input logic hq,
                        input logic g, input logic sm, input logic [9:0] expv,
                        input string tag);
        drive(e, rdy, hq, g, sm);
        exp_q.push_back(expv);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        check_sb();
    endtask

    task automatic expect_now(input logic [9:0] expv, input string tag);
        exp_q.push_back(expv);
        tag_q.push_back(tag);
        check_sb();
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        #12;
        expect_now(ex(3'b000, 0, 0, 0, 4'd0), "reset_state");
        reset = 1'b1;

        // Free-running sequence, all phases ready
        step(1, 3'b111, 0, 0, 0, ex(3'b001, 1, 0, 0, 4'd0), "run_p0");
        step(1, 3'b111, 0, 0, 0, ex(3'b010, 1, 0, 0, 4'd0), "run_p1");
        step(1, 3'b111, 0, 0, 0, ex(3'b100, 1, 0, 0, 4'd0), "run_p2");
        step(1, 3'b111, 0, 0, 0, ex(3'b001, 1, 0, 0, 4'd0), "run_wrap");

        // Phase 1 stretched by three wait states
        step(1, 3'b101, 0, 0, 0, ex(3'b010, 1, 0, 0, 4'd0), "wait_enter");
        step(1, 3'b101, 0, 0, 0, ex(3'b010, 0, 0, 0, 4'd1), "wait_1");
        step(1, 3'b101, 0, 0, 0, ex(3'b010, 0, 0, 0, 4'd2), "wait_2");
        step(1, 3'b101, 0, 0, 0, ex(3'b010, 0, 0, 0, 4'd3), "wait_3");
        step(1, 3'b111, 0, 0, 0, ex(3'b100, 1, 0, 0, 4'd0), "wait_leave");
        step(1, 3'b111, 0, 0, 0, ex(3'b001, 1, 0, 0, 4'd0), "wait_wrap");

        // Clock enable low freezes phase and wait count even with ready high
        step(1, 3'b110, 0, 0, 0, ex(3'b001, 0, 0, 0, 4'd1), "en_pre");
        for (int i = 0; i < 5; i++)
            step(0, 3'b111, 0, 0, 0, ex(3'b001, 0, 0, 0, 4'd1), $sformatf("en_hold_%0d", i));
        step(1, 3'b111, 0, 0, 0, ex(3'b010, 1, 0, 0, 4'd0), "en_resume");

        // Asynchronous reset in the middle of phase 1
        #2 reset = 1'b0;
        #1 expect_now(ex(3'b000, 0, 0, 0, 4'd0), "async_reset");
        step(1, 3'b111, 0, 0, 0, ex(3'b000, 0, 0, 0, 4'd0), "reset_held");
        reset = 1'b1;
        step(1, 3'b111, 0, 0, 0, ex(3'b001, 1, 0, 0, 4'd0), "reset_release");

        // Single-step: one instruction per go pulse
        step(1, 3'b111, 0, 0, 1, ex(3'b010, 1, 0, 0, 4'd0), "step_p1");
        step(1, 3'b111, 0, 0, 1, ex(3'b100, 1, 0, 0, 4'd0), "step_p2");
        step(1, 3'b111, 0, 0, 1, ex(3'b000, 0, 1, 0, 4'd0), "step_halt");
        step(1, 3'b111, 0, 0, 1, ex(3'b000, 0, 1, 0, 4'd0), "step_wait_go");
        step(1, 3'b111, 0, 1, 1, ex(3'b001, 1, 0, 0, 4'd0), "step_go_p0");
        step(1, 3'b111, 0, 0, 1, ex(3'b010, 1, 0, 0, 4'd0), "step_go_p1");
        step(1, 3'b111, 0, 0, 1, ex(3'b100, 1, 0, 0, 4'd0), "step_go_p2");
        step(1, 3'b111, 0, 0, 1, ex(3'b000, 0, 1, 0, 4'd0), "step_rehalt");

        // go and halt_req together: go runs one instruction, then re-halt
        step(1, 3'b111, 1, 1, 0, ex(3'b001, 1, 0, 0, 4'd0), "gohalt_p0");
        step(1, 3'b111, 1, 0, 0, ex(3'b010, 1, 0, 0, 4'd0), "gohalt_p1");
        step(1, 3'b111, 1, 0, 0, ex(3'b100, 1, 0, 0, 4'd0), "gohalt_p2");
        step(1, 3'b111, 1, 0, 0, ex(3'b000, 0, 1, 0, 4'd0), "gohalt_halt");

        // halt_req pulse away from the boundary is ignored
        step(1, 3'b111, 0, 1, 0, ex(3'b001, 1, 0, 0, 4'd0), "pulse_go");
        step(1, 3'b111, 0, 0, 0, ex(3'b010, 1, 0, 0, 4'd0), "pulse_p1");
        step(1, 3'b111, 1, 0, 0, ex(3'b100, 1, 0, 0, 4'd0), "pulse_p2");
        step(1, 3'b111, 0, 0, 0, ex(3'b001, 1, 0, 0, 4'd0), "pulse_wrap");

        // Phase 0 never ready: timeout on the fourth cycle, go then ignored
        step(1, 3'b110, 0, 0, 0, ex(3'b001, 0, 0, 0, 4'd1), "to_w1");
        step(1, 3'b110, 0, 0, 0, ex(3'b001, 0, 0, 0, 4'd2), "to_w2");
        step(1, 3'b110, 0, 0, 0, ex(3'b001, 0, 0, 0, 4'd3), "to_w3");
        step(1, 3'b110, 0, 0, 0, ex(3'b000, 0, 1, 1, 4'd0), "to_fire");
        step(1, 3'b111, 0, 1, 0, ex(3'b000, 0, 1, 1, 4'd0), "to_go_ignored");
        step(1, 3'b111, 0, 0, 0, ex(3'b000, 0, 1, 1, 4'd0), "to_sticky");
        #2 reset = 1'b0;
        #1 expect_now(ex(3'b000, 0, 0, 0, 4'd0), "to_reset_clears");
        #2 reset = 1'b1;
        step(1, 3'b111, 0, 0, 0, ex(3'b001, 1, 0, 0, 4'd0), "to_restart");

`ifdef PHASE_SEQ_RETIRE_CNT_EN
        cmp("retire_after_reset", bus.retire_cnt, 32'd0);
        for (int k = 0; k < 30; k++) begin
            logic [2:0] p;
            p = 3'b001 << ((k + 1) % 3);
            step(1, 3'b111, 0, 0, 0, ex(p, 1, 0, 0, 4'd0), $sformatf("retire_run_%0d", k));
        end
        cmp("retire_ten", bus.retire_cnt, 32'd10);
        step(1, 3'b110, 0, 0, 0, ex(3'b001, 0, 0, 0, 4'd1), "retire_to_w1");
        step(1, 3'b110, 0, 0, 0, ex(3'b001, 0, 0, 0, 4'd2), "retire_to_w2");
        step(1, 3'b110, 0, 0, 0, ex(3'b001, 0, 0, 0, 4'd3), "retire_to_w3");
        step(1, 3'b110, 0, 0, 0, ex(3'b000, 0, 1, 1, 4'd0), "retire_to_fire");
        cmp("retire_after_timeout", bus.retire_cnt, 32'd10);
`endif

        cmp("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
